// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU.
// The ALU_MC_DIV_EN macro adds the DIV state to the FSM state type.
package alu_mc_pkg;

  localparam int unsigned ALU_MC_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_SLTU  = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_MULT  = 4'd8,
    ALU_MULTU = 4'd9,
    ALU_DIV   = 4'd10,
    ALU_DIVU  = 4'd11,
    ALU_MFHI  = 4'd12,
    ALU_MFLO  = 4'd13,
    ALU_RSV14 = 4'd14,
    ALU_RSV15 = 4'd15
  } alu_ctl_e;

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative magnitude datapath: shift-add multiplier and, with
// ALU_MC_DIV_EN defined, a restoring divider. One step per enabled cycle,
// WIDTH steps per operation; last flags the final step.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_MC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
`ifdef ALU_MC_DIV_EN
  input  logic             div_sel,
`endif
  input  logic             step,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic             last,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] nxt_acc;
  logic [WIDTH-1:0] nxt_lo;
`ifdef ALU_MC_DIV_EN
  logic             mode_div;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
`endif

  assign last   = step && (cnt == CW'(WIDTH - 1));
  assign out_hi = acc;
  assign out_lo = lo_q;

  // Next value of the accumulator / shift register for one iteration
  always_comb begin
    mul_sum = {1'b0, acc} + (lo_q[0] ? {1'b0, opnd} : '0);
    nxt_acc = mul_sum[WIDTH:1];
    nxt_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    div_shift = {acc, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (mode_div) begin
      nxt_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
      nxt_lo  = {lo_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  // Operand load, per-cycle step and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      lo_q <= '0;
      opnd <= '0;
      cnt  <= '0;
`ifdef ALU_MC_DIV_EN
      mode_div <= 1'b0;
`endif
    end else if (load) begin
      acc  <= '0;
      lo_q <= mag_a;
      opnd <= mag_b;
      cnt  <= '0;
`ifdef ALU_MC_DIV_EN
      mode_div <= div_sel;
`endif
    end else if (step) begin
      acc  <= nxt_acc;
      lo_q <= nxt_lo;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic ops, iterative multiply and
// (when ALU_MC_DIV_EN is defined) divide, with hi/lo result registers.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_MC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  alu_ctl_e         op;
  state_e           state;
  logic             is_mul, is_div, is_illegal, signed_op;
  logic             neg_a, neg_b, neg_p;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] add_res, sub_res, sc_res;
  logic             sc_ovf;
  logic             iter_load, iter_step, iter_last;
  logic [WIDTH-1:0] iter_hi, iter_lo, fix_hi, fix_lo;
`ifdef ALU_MC_DIV_EN
  logic             div_op, neg_r;
`endif

  assign op = alu_ctl_e'(alu_ctl);
  assign is_mul = (op == ALU_MULT) || (op == ALU_MULTU);
`ifdef ALU_MC_DIV_EN
  assign is_div    = (op == ALU_DIV) || (op == ALU_DIVU);
  assign iter_step = (state == ST_MUL) || (state == ST_DIV);
`else
  assign is_div    = 1'b0;
  assign iter_step = (state == ST_MUL);
`endif
  assign is_illegal = (op == ALU_RSV14) || (op == ALU_RSV15) ||
                      (!is_div && ((op == ALU_DIV) || (op == ALU_DIVU)));
  assign signed_op = (op == ALU_MULT) || (op == ALU_DIV);
  assign neg_a = signed_op && src_a[WIDTH-1];
  assign neg_b = signed_op && src_b[WIDTH-1];
  assign mag_a = neg_a ? -src_a : src_a;
  assign mag_b = neg_b ? -src_b : src_b;
  assign iter_load = (state == ST_IDLE) && start &&
                     (is_mul || (is_div && (src_b != '0)));
  assign zero = (result == '0);

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (iter_load),
`ifdef ALU_MC_DIV_EN
    .div_sel (is_div),
`endif
    .step    (iter_step),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .last    (iter_last),
    .out_hi  (iter_hi),
    .out_lo  (iter_lo)
  );

  // Single-cycle result and signed add/sub overflow
  always_comb begin
    add_res = src_a + src_b;
    sub_res = src_a - src_b;
    sc_res  = '0;
    sc_ovf  = 1'b0;
    case (op)
      ALU_ADD: begin
        sc_res = add_res;
        sc_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_res[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = sub_res;
        sc_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_res[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_AND:  sc_res = src_a & src_b;
      ALU_OR:   sc_res = src_a | src_b;
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      ALU_XOR:  sc_res = src_a ^ src_b;
      ALU_NOR:  sc_res = ~(src_a | src_b);
      ALU_MFHI: sc_res = hi;
      ALU_MFLO: sc_res = lo;
      default:  sc_res = '0;
    endcase
  end

  // Sign correction of the magnitude product / quotient / remainder
  always_comb begin
    {fix_hi, fix_lo} = neg_p ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
`ifdef ALU_MC_DIV_EN
    if (div_op) begin
      fix_lo = neg_p ? -iter_lo : iter_lo;
      fix_hi = neg_r ? -iter_hi : iter_hi;
    end
`endif
  end

  // Control FSM and all output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      result  <= '0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      neg_p   <= 1'b0;
`ifdef ALU_MC_DIV_EN
      div_op  <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul) begin
              state   <= ST_MUL;
              busy    <= 1'b1;
              ovf     <= 1'b0;
              illegal <= 1'b0;
              neg_p   <= neg_a ^ neg_b;
`ifdef ALU_MC_DIV_EN
              div_op  <= 1'b0;
            end else if (is_div) begin
              ovf     <= 1'b0;
              illegal <= 1'b0;
              if (src_b == '0) begin
                // Divide by zero completes immediately without iterating
                lo   <= '1;
                hi   <= src_a;
                done <= 1'b1;
              end else begin
                state  <= ST_DIV;
                busy   <= 1'b1;
                div_op <= 1'b1;
                neg_p  <= neg_a ^ neg_b;
                neg_r  <= neg_a;
              end
`endif
            end else begin
              result  <= sc_res;
              ovf     <= sc_ovf;
              illegal <= is_illegal;
              done    <= 1'b1;
            end
          end
        end
        ST_MUL: if (iter_last) state <= ST_FIX;
`ifdef ALU_MC_DIV_EN
        ST_DIV: if (iter_last) state <= ST_FIX;
`endif
        ST_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32). Expected values come from an
// arithmetic reference model of hi/lo/result; divide expectations follow
// whether ALU_MC_DIV_EN is defined for the build.
module tb_alu_mc;

  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd4, OP_SLTU = 4'd5,
                         OP_MULT = 4'd8, OP_MULTU = 4'd9, OP_DIV = 4'd10, OP_DIVU = 4'd11,
                         OP_MFHI = 4'd12, OP_MFLO = 4'd13;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alu_ctl = '0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic [W-1:0] result, hi, lo;
  logic         zero, ovf, illegal, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_res, m_hi, m_lo;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctl(alu_ctl),
    .src_a(src_a), .src_b(src_b), .result(result), .zero(zero), .ovf(ovf),
    .illegal(illegal), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: applies one operation to the architectural state
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic ov, output logic il, output int lat);
    longint sa, sb, s, q, rm;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = m_res; ov = 1'b0; il = 1'b0; lat = 1;
    case (op)
      0: begin s = sa + sb; r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      1: begin s = sa - sb; r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      2: r = a & b;
      3: r = a | b;
      4: r = (sa < sb) ? 1 : 0;
      5: r = (a < b) ? 1 : 0;
      6: r = a ^ b;
      7: r = ~(a | b);
      8: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; lat = W + 2; end
      9: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; lat = W + 2; end
`ifdef ALU_MC_DIV_EN
      10, 11: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (op == 10) begin q = sa / sb; rm = sa % sb; m_lo = q[31:0]; m_hi = rm[31:0]; lat = W + 2; end
        else begin m_lo = a / b; m_hi = a % b; lat = W + 2; end
      end
`endif
      12: r = m_hi;
      13: r = m_lo;
      default: begin r = '0; il = 1'b1; end
    endcase
    m_res = r;
  endtask

  // Drives one start pulse and waits (bounded) for done; lat=-1 on timeout
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy_first);
    @(negedge clk);
    start = 1'b1; alu_ctl = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    busy_first = busy;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_res = '0; m_hi = '0; m_lo = '0;
    n_cmp++;
    if ({result, zero, ovf, illegal, hi, lo, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got res=%h z=%b ov=%b il=%b hi=%h lo=%h busy=%b done=%b want res=0 z=1 others 0",
               result, zero, ovf, illegal, hi, lo, busy, done);
    end
  endtask

  task automatic test_directed();
    logic [3:0]   ops [15];
    logic [W-1:0] as  [15];
    logic [W-1:0] bs  [15];
    logic [W-1:0] e_res;
    logic         e_ov, e_il, bsy;
    int           e_lat, lat;
    ops = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_MULT, OP_MFHI, OP_MULTU, OP_MFLO, OP_DIV,
            OP_DIV, OP_DIV, OP_DIVU, OP_MFLO, OP_MFHI, 4'd14};
    as  = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFE, 32'd0,
            32'hFFFFFFF9, 32'd5, 32'h80000000, 32'd9, 32'd0, 32'd0, 32'h1234};
    bs  = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd3, 32'd0, 32'd3, 32'd0,
            32'd2, 32'd0, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, 32'h5678};
    for (int i = 0; i < 15; i++) begin
      model(ops[i], as[i], bs[i], e_res, e_ov, e_il, e_lat);
      run_op(ops[i], as[i], bs[i], lat, bsy);
      n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL dir%0d_latency op=%0d got %0d want %0d", i, ops[i], lat, e_lat); end
      n_cmp++; if (result !== e_res) begin n_bad++; $display("FAIL dir%0d_result op=%0d got %h want %h", i, ops[i], result, e_res); end
      n_cmp++; if (zero !== (e_res == 0)) begin n_bad++; $display("FAIL dir%0d_zero got %b want %b", i, zero, e_res == 0); end
      n_cmp++; if (ovf !== e_ov) begin n_bad++; $display("FAIL dir%0d_ovf op=%0d got %b want %b", i, ops[i], ovf, e_ov); end
      n_cmp++; if (illegal !== e_il) begin n_bad++; $display("FAIL dir%0d_illegal op=%0d got %b want %b", i, ops[i], illegal, e_il); end
      n_cmp++; if (hi !== m_hi) begin n_bad++; $display("FAIL dir%0d_hi op=%0d got %h want %h", i, ops[i], hi, m_hi); end
      n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL dir%0d_lo op=%0d got %h want %h", i, ops[i], lo, m_lo); end
      n_cmp++; if (bsy !== (e_lat > 1)) begin n_bad++; $display("FAIL dir%0d_busy op=%0d got %b want %b", i, ops[i], bsy, e_lat > 1); end
    end
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] a, b, e_res;
    logic         e_ov, e_il, bsy;
    int           e_lat, lat;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'h7FFFFFFF; b = 32'($urandom_range(0, 3)); end
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model(op, a, b, e_res, e_ov, e_il, e_lat);
      run_op(op, a, b, lat, bsy);
      n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", i, op, lat, e_lat); end
      n_cmp++; if ({result, zero} !== {e_res, e_res == 0}) begin n_bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h/%b want %h", i, op, a, b, result, zero, e_res); end
      n_cmp++; if ({ovf, illegal} !== {e_ov, e_il}) begin n_bad++; $display("FAIL rnd%0d_flags op=%0d got ovf=%b il=%b want ovf=%b il=%b", i, op, ovf, illegal, e_ov, e_il); end
      n_cmp++; if ({hi, lo} !== {m_hi, m_lo}) begin n_bad++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got %h_%h want %h_%h", i, op, a, b, hi, lo, m_hi, m_lo); end
      n_cmp++; if (bsy !== (e_lat > 1)) begin n_bad++; $display("FAIL rnd%0d_busy op=%0d got %b want %b", i, op, bsy, e_lat > 1); end
    end
  endtask

  // MULT while ADD start is held every cycle; the ADD in the done cycle is taken
  task automatic test_back_to_back();
    logic [W-1:0] e_res, old_res;
    logic         e_ov, e_il, bsy;
    int           e_lat, lat, cyc;
    model(OP_ADD, 32'd100, 32'd23, e_res, e_ov, e_il, e_lat);
    run_op(OP_ADD, 32'd100, 32'd23, lat, bsy);
    old_res = m_res;
    model(OP_MULT, 32'hFFFFFFFE, 32'd3, e_res, e_ov, e_il, e_lat);
    @(negedge clk);
    start = 1'b1; alu_ctl = OP_MULT; src_a = 32'hFFFFFFFE; src_b = 32'd3;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        n_cmp++;
        if ({busy, result} !== {1'b1, old_res}) begin
          n_bad++; $display("FAIL b2b_hold cyc=%0d got busy=%b res=%h want busy=1 res=%h", cyc, busy, result, old_res);
        end
      end
      alu_ctl = OP_ADD; src_a = $urandom; src_b = $urandom;
    end while (!done && cyc < 60);
    n_cmp++; if (cyc !== W + 2) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", cyc, W + 2); end
    n_cmp++; if ({hi, lo} !== {m_hi, m_lo}) begin n_bad++; $display("FAIL b2b_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    model(OP_ADD, src_a, src_b, e_res, e_ov, e_il, e_lat);
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if ({done, result} !== {1'b1, e_res}) begin n_bad++; $display("FAIL b2b_next_add got done=%b res=%h want done=1 res=%h", done, result, e_res); end
  endtask

  // Reset in the middle of a multiply: abort with no done and cleared state
  task automatic test_abort();
    logic [W-1:0] e_res, old_res;
    logic         e_ov, e_il, bsy, seen;
    int           e_lat, lat;
    model(OP_ADD, 32'd7, 32'd8, e_res, e_ov, e_il, e_lat);
    run_op(OP_ADD, 32'd7, 32'd8, lat, bsy);
    old_res = m_res;
    @(negedge clk);
    start = 1'b1; alu_ctl = OP_MULT; src_a = $urandom; src_b = $urandom;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, result} !== {1'b1, 1'b0, old_res}) begin
        n_bad++; $display("FAIL abort_hold cyc=%0d got busy=%b done=%b res=%h want 1/0/%h", c, busy, done, result, old_res);
      end
      alu_ctl = OP_ADD; src_a = $urandom; src_b = $urandom;
    end
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_res = '0; m_hi = '0; m_lo = '0;
    n_cmp++;
    if ({busy, done, hi, lo, result} !== {1'b0, 1'b0, 64'h0, 32'h0}) begin
      n_bad++; $display("FAIL abort_state got busy=%b done=%b hi=%h lo=%h res=%h want all 0", busy, done, hi, lo, result);
    end
    seen = 1'b0;
    repeat (W + 8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got done seen=%b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_directed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
